// File: rtl/axis_spi_tx.sv
// axis_spi_tx: AXI-Stream sink feeding an SPI mode-0 master transmitter.
// Each accepted beat is shifted out on mosi_o with sck_o generated from clk_i
// and csn_o framing the transfer. All outputs are registered.
//
// Build option: define AXIS_SPI_TX_FRAME_EN to keep csn_o low across the beats
// of one packet (tlast_i closes the frame). Without it every beat is its own
// frame and tlast_i is ignored.

`timescale 1ns/1ps

module axis_spi_tx #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned CS_SETUP  = 2,
  parameter int unsigned CS_HOLD   = 2,
  parameter bit          MSB_FIRST = 1'b1,
  localparam int unsigned KEEP_W   = (DATA_W >= 8) ? DATA_W / 8 : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] tdata_i,
  input  logic              tvalid_i,
  output logic              tready_o,
  input  logic              tlast_i,
  input  logic [KEEP_W-1:0] tkeep_i,
  output logic              sck_o,
  output logic              mosi_o,
  output logic              csn_o,
  output logic              busy_o
);

  // One shared down-counter times the setup, sck half-periods and hold.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  localparam int unsigned TMR_MAX = max3(CLK_DIV, CS_SETUP, CS_HOLD);
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam int unsigned BIT_W   = $clog2(DATA_W + 1);

  localparam logic [TMR_W-1:0] TmrSetup = TMR_W'(CS_SETUP - 1);
  localparam logic [TMR_W-1:0] TmrHalf  = TMR_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] TmrHold  = TMR_W'(CS_HOLD - 1);
  localparam logic [BIT_W-1:0] BitsWord = BIT_W'(DATA_W);

`ifdef AXIS_SPI_TX_FRAME_EN
  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StHold,
    StNext
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StHold
  } state_e;
`endif

  state_e              state_q;
  logic [DATA_W-2:0]   shreg_q;    // bits still to send after the one on mosi_q
  logic [BIT_W-1:0]    bit_cnt_q;  // bits left in the word, including the current one
  logic [TMR_W-1:0]    tmr_q;
  logic                sck_q;
  logic                mosi_q;
  logic                csn_q;
  logic                tready_q;
  logic                busy_q;
`ifdef AXIS_SPI_TX_FRAME_EN
  logic                last_q;
`endif

  // Present the word in transmit order so the shifter always shifts left.
  function automatic logic [DATA_W-1:0] order_bits(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    if (MSB_FIRST) begin
      r = d;
    end else begin
      for (int i = 0; i < int'(DATA_W); i++) begin
        r[DATA_W-1-i] = d[i];
      end
    end
    return r;
  endfunction

  logic [DATA_W-1:0] load_bits;
  assign load_bits = order_bits(tdata_i);

  logic accept;
  assign accept = tvalid_i & tready_q;

`ifdef AXIS_SPI_TX_FRAME_EN
  logic unused_in;
  assign unused_in = ^tkeep_i;
`else
  logic unused_in;
  assign unused_in = ^{tkeep_i, tlast_i};
`endif

  // Transfer FSM: handshake, chip select, sck phases and the bit shifter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      tmr_q     <= '0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      csn_q     <= 1'b1;
      tready_q  <= 1'b0;
      busy_q    <= 1'b0;
`ifdef AXIS_SPI_TX_FRAME_EN
      last_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          csn_q    <= 1'b1;
          sck_q    <= 1'b0;
          tready_q <= 1'b1;
          busy_q   <= 1'b0;
          if (accept) begin
            shreg_q   <= load_bits[DATA_W-2:0];
            mosi_q    <= load_bits[DATA_W-1];
            bit_cnt_q <= BitsWord;
`ifdef AXIS_SPI_TX_FRAME_EN
            last_q    <= tlast_i;
`endif
            tmr_q     <= TmrSetup;
            csn_q     <= 1'b0;
            tready_q  <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= StSetup;
          end
        end

        StSetup: begin
          if (tmr_q == '0) begin
            tmr_q   <= TmrHalf;
            state_q <= StShift;
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end

        StShift: begin
          if (tmr_q != '0) begin
            tmr_q <= tmr_q - TMR_W'(1);
          end else if (!sck_q) begin
            // End of the low phase: rising edge, mosi_q already stable.
            sck_q <= 1'b1;
            tmr_q <= TmrHalf;
          end else begin
            // End of the high phase: falling edge, advance to the next bit.
            sck_q     <= 1'b0;
            tmr_q     <= TmrHalf;
            bit_cnt_q <= bit_cnt_q - BIT_W'(1);
            if (bit_cnt_q == BIT_W'(1)) begin
`ifdef AXIS_SPI_TX_FRAME_EN
              if (!last_q) begin
                tready_q <= 1'b1;
                state_q  <= StNext;
              end else begin
                tmr_q   <= TmrHold;
                state_q <= StHold;
              end
`else
              tmr_q   <= TmrHold;
              state_q <= StHold;
`endif
            end else begin
              mosi_q  <= shreg_q[DATA_W-2];
              shreg_q <= shreg_q << 1;
            end
          end
        end

        StHold: begin
          if (tmr_q == '0) begin
            csn_q    <= 1'b1;
            tready_q <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= StIdle;
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end

`ifdef AXIS_SPI_TX_FRAME_EN
        StNext: begin
          // Mid-packet gap: csn_o stays low, the next beat skips the setup time.
          if (accept) begin
            shreg_q   <= load_bits[DATA_W-2:0];
            mosi_q    <= load_bits[DATA_W-1];
            bit_cnt_q <= BitsWord;
            last_q    <= tlast_i;
            tmr_q     <= TmrHalf;
            tready_q  <= 1'b0;
            state_q   <= StShift;
          end
        end
`endif

        default: begin
          csn_q    <= 1'b1;
          sck_q    <= 1'b0;
          tready_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

  assign tready_o = tready_q;
  assign sck_o    = sck_q;
  assign mosi_o   = mosi_q;
  assign csn_o    = csn_q;
  assign busy_o   = busy_q;

  // Protocol sanity: sck only toggles inside a frame, data held while sck is high.
  a_sck_in_frame: assert property (@(posedge clk_i) disable iff (rst_i) sck_o |-> !csn_o);
  a_mosi_stable:  assert property (@(posedge clk_i) disable iff (rst_i)
                                   (sck_o && $past(sck_o)) |-> $stable(mosi_o));
  a_idle_desel:   assert property (@(posedge clk_i) disable iff (rst_i) !busy_o |-> csn_o);

endmodule
